// File: rtl/clock_meter_pkg.sv
// Shared types and elaboration helpers for the clock period meter.
// The FSM state type is also exported on the top level's debug port.
package clock_meter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2
  } state_t;

  // Longest period (in reference cycles) accepted before loss of signal.
  function automatic int unsigned timeout_cycles(input int unsigned ref_freq,
                                                 input int unsigned min_freq);
    return ref_freq / min_freq;
  endfunction

endpackage

// File: rtl/clock_period_meter_edge_sync.sv
// Three-flop synchronizer with rising-edge detect for any asynchronous input.
// rise is high for exactly one clk cycle per synchronized low-to-high transition.
module edge_sync (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic rise
);

  logic sync1_q, sync2_q, sync3_q;
  logic sync1_d, sync2_d, sync3_d;

  always_comb begin
    sync1_d = async_in;
    sync2_d = sync1_q;
    sync3_d = sync2_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      sync3_q <= sync3_d;
    end
  end

  assign rise = sync2_q & ~sync3_q;

endmodule

// File: rtl/clock_period_meter.sv
// Measures the period of an asynchronous clock/tick in clk cycles between
// consecutive rising edges, and flags loss of signal after a fixed timeout.
module clock_period_meter
  import clock_meter_pkg::*;
#(
  parameter int unsigned REF_FREQUENCY = 50000000,
  parameter int unsigned MIN_FREQUENCY = 1000,
  parameter int unsigned CNT_WIDTH     = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clk_in,
  input  logic                 enable,
  output logic [CNT_WIDTH-1:0] period_out,
  output logic                 period_valid,
  output logic                 timeout,
  output state_t               dbg_state
);

  localparam int unsigned TIMEOUT_CYCLES = timeout_cycles(REF_FREQUENCY, MIN_FREQUENCY);
  localparam logic [CNT_WIDTH-1:0] TIMEOUT_CNT = CNT_WIDTH'(TIMEOUT_CYCLES);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE     = CNT_WIDTH'(1);

  logic rise;

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0] period_q, period_d;
  logic                 valid_q, valid_d;
  logic                 timeout_q, timeout_d;

  edge_sync u_edge_sync (
    .clk      (clk),
    .reset    (reset),
    .async_in (clk_in),
    .rise     (rise)
  );

  // enable has priority over everything; a rise coinciding with the
  // timeout count is still reported as a measurement.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    period_d  = period_q;
    valid_d   = 1'b0;
    timeout_d = timeout_q;
    if (!enable) begin
      state_d   = IDLE;
      cnt_d     = '0;
      timeout_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = ARM;
        end
        ARM: begin
          if (rise) begin
            cnt_d   = CNT_ONE;
            state_d = MEASURE;
          end
        end
        MEASURE: begin
          if (rise) begin
            period_d  = cnt_q;
            valid_d   = 1'b1;
            timeout_d = 1'b0;
            cnt_d     = CNT_ONE;
          end else if (cnt_q == TIMEOUT_CNT) begin
            timeout_d = 1'b1;
            state_d   = ARM;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      period_q  <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      period_q  <= period_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
    end
  end

  assign period_out   = period_q;
  assign period_valid = valid_q;
  assign timeout      = timeout_q;
  assign dbg_state    = state_q;

endmodule
